// File: rtl/mc_alu.sv
`default_nettype none
// ============================================================================
// Module   : mc_alu
// Brief    : Multi-cycle ALU with a valid/ready request/response handshake.
//            Single-cycle ops finish in one cycle, shifts move one bit per
//            cycle and the optional multiplier is a radix-2 shift-add unit.
//            Optional feature macro: MC_ALU_MUL_EN (MUL / MULHU ops).
// Revision : 1.0 - initial release
// ============================================================================
module mc_alu #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] LINK_OFF = XLEN'(32'h0100_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ALU_op,
    input  logic [XLEN-1:0] input1,
    input  logic [XLEN-1:0] input2,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [XLEN-1:0] alu_out,
    output logic            zero,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = SH_W + 1;

    localparam logic [4:0] OP_LUI   = 5'b00000;
    localparam logic [4:0] OP_ALUI  = 5'b00001;
    localparam logic [4:0] OP_ADD   = 5'b00010;
    localparam logic [4:0] OP_BEQ   = 5'b00011;
    localparam logic [4:0] OP_BNE   = 5'b00100;
    localparam logic [4:0] OP_BLT   = 5'b00101;
    localparam logic [4:0] OP_BGE   = 5'b00110;
    localparam logic [4:0] OP_BLTU  = 5'b00111;
    localparam logic [4:0] OP_BGEU  = 5'b01000;
    localparam logic [4:0] OP_SLT   = 5'b01001;
    localparam logic [4:0] OP_SLTU  = 5'b01010;
    localparam logic [4:0] OP_XOR   = 5'b01011;
    localparam logic [4:0] OP_OR    = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_SLL   = 5'b01110;
    localparam logic [4:0] OP_SRL   = 5'b01111;
    localparam logic [4:0] OP_SRA   = 5'b10000;
    localparam logic [4:0] OP_SUB   = 5'b10001;
    localparam logic [4:0] OP_PASSB = 5'b10010;
    localparam logic [4:0] OP_LINK  = 5'b10011;
`ifdef MC_ALU_MUL_EN
    localparam logic [4:0] OP_MUL   = 5'b10100;
    localparam logic [4:0] OP_MULHU = 5'b10101;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
`ifdef MC_ALU_MUL_EN
        MUL   = 2'd2,
`endif
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [4:0]      op_q;
    logic [CNT_W-1:0] cnt;
    logic            accept;
    logic            is_shift_in;
    logic [SH_W-1:0] shamt_in;
    logic [XLEN-1:0] single_res;
    logic            single_zero;
    logic [XLEN-1:0] shift_step;
    logic [XLEN-1:0] lui_b;

`ifdef MC_ALU_MUL_EN
    logic            is_mul_in;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mul_hi;
    logic [XLEN-1:0] mul_lo;
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_next;
    logic [XLEN-1:0] mul_lo_next;
`endif

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign accept      = in_valid & in_ready;
    assign shamt_in    = input2[SH_W-1:0];
    assign is_shift_in = (ALU_op == OP_SLL) || (ALU_op == OP_SRL) || (ALU_op == OP_SRA);
    assign lui_b       = {input2[XLEN-1:12], 12'b0};
`ifdef MC_ALU_MUL_EN
    assign is_mul_in   = (ALU_op == OP_MUL) || (ALU_op == OP_MULHU);
`endif

    // Results of every op that completes in the accept cycle
    always_comb begin
        single_res  = '0;
        single_zero = 1'b0;
        case (ALU_op)
            OP_LUI:   single_res  = lui_b;
            OP_ALUI:  single_res  = input1 + lui_b;
            OP_ADD:   single_res  = input1 + input2;
            OP_BEQ:   single_zero = (input1 == input2);
            OP_BNE:   single_zero = (input1 != input2);
            OP_BLT:   single_zero = ($signed(input1) <  $signed(input2));
            OP_BGE:   single_zero = ($signed(input1) >= $signed(input2));
            OP_BLTU:  single_zero = (input1 <  input2);
            OP_BGEU:  single_zero = (input1 >= input2);
            OP_SLT:   single_res  = {{(XLEN-1){1'b0}}, ($signed(input1) < $signed(input2))};
            OP_SLTU:  single_res  = {{(XLEN-1){1'b0}}, (input1 < input2)};
            OP_XOR:   single_res  = input1 ^ input2;
            OP_OR:    single_res  = input1 | input2;
            OP_AND:   single_res  = input1 & input2;
            OP_SUB:   single_res  = input1 - input2;
            OP_PASSB: single_res  = input2;
            OP_LINK:  single_res  = input1 + input2 - LINK_OFF;
            default:  single_res  = '0;
        endcase
    end

    // One-bit shift of the working value held in alu_out
    always_comb begin
        shift_step = alu_out;
        case (op_q)
            OP_SLL:  shift_step = {alu_out[XLEN-2:0], 1'b0};
            OP_SRL:  shift_step = {1'b0, alu_out[XLEN-1:1]};
            default: shift_step = {alu_out[XLEN-1], alu_out[XLEN-1:1]};
        endcase
    end

`ifdef MC_ALU_MUL_EN
    // Radix-2 shift-add step: conditionally add multiplicand, then shift {hi,lo} right
    always_comb begin
        mul_sum     = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
        mul_hi_next = mul_sum[XLEN:1];
        mul_lo_next = {mul_sum[0], mul_lo[XLEN-1:1]};
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_shift_in) begin
                        state_next = (shamt_in == '0) ? DONE : SHIFT;
                    end
`ifdef MC_ALU_MUL_EN
                    else if (is_mul_in) begin
                        state_next = MUL;
                    end
`endif
                    else begin
                        state_next = DONE;
                    end
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(1)) state_next = DONE;
            end
`ifdef MC_ALU_MUL_EN
            MUL: begin
                if (cnt == CNT_W'(1)) state_next = DONE;
            end
`endif
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch request on accept, iterate shifts/multiply, hold in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            cnt     <= '0;
            alu_out <= '0;
            zero    <= 1'b0;
`ifdef MC_ALU_MUL_EN
            mcand   <= '0;
            mul_hi  <= '0;
            mul_lo  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= ALU_op;
                        if (is_shift_in) begin
                            alu_out <= input1;
                            zero    <= 1'b0;
                            cnt     <= {1'b0, shamt_in};
                        end
`ifdef MC_ALU_MUL_EN
                        else if (is_mul_in) begin
                            alu_out <= '0;
                            zero    <= 1'b0;
                            cnt     <= CNT_W'(XLEN);
                            mcand   <= input1;
                            mul_hi  <= '0;
                            mul_lo  <= input2;
                        end
`endif
                        else begin
                            alu_out <= single_res;
                            zero    <= single_zero;
                        end
                    end
                end
                SHIFT: begin
                    alu_out <= shift_step;
                    cnt     <= cnt - CNT_W'(1);
                end
`ifdef MC_ALU_MUL_EN
                MUL: begin
                    mul_hi <= mul_hi_next;
                    mul_lo <= mul_lo_next;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        alu_out <= (op_q == OP_MULHU) ? mul_hi_next : mul_lo_next;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_alu
// Brief    : Self-checking bench for mc_alu: directed corner cases plus
//            randomized ops scored against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_alu;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      ALU_op;
    logic [XLEN-1:0] input1;
    logic [XLEN-1:0] input2;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] alu_out;
    logic            zero;
    logic            out_valid;
    logic            out_ready;

    int total = 0;
    int bad   = 0;

    mc_alu #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .ALU_op    (ALU_op),
        .input1    (input1),
        .input2    (input2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_out   (alu_out),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: result, branch flag and latency from the op definitions
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output int lat);
        logic [63:0] p;
        logic [31:0] lui;
        int sh;
        sh  = int'(b[4:0]);
        p   = {32'b0, a} * {32'b0, b};
        lui = {b[31:12], 12'b0};
        r   = 32'd0;
        z   = 1'b0;
        lat = 1;
        case (op)
            5'd0:  r = lui;
            5'd1:  r = a + lui;
            5'd2:  r = a + b;
            5'd3:  z = (a == b);
            5'd4:  z = (a != b);
            5'd5:  z = ($signed(a) <  $signed(b));
            5'd6:  z = ($signed(a) >= $signed(b));
            5'd7:  z = (a <  b);
            5'd8:  z = (a >= b);
            5'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd10: r = (a < b) ? 32'd1 : 32'd0;
            5'd11: r = a ^ b;
            5'd12: r = a | b;
            5'd13: r = a & b;
            5'd14: begin r = a << sh; lat = sh + 1; end
            5'd15: begin r = a >> sh; lat = sh + 1; end
            5'd16: begin r = $signed(a) >>> sh; lat = sh + 1; end
            5'd17: r = a - b;
            5'd18: r = b;
            5'd19: r = a + b - 32'h0100_0000;
`ifdef MC_ALU_MUL_EN
            5'd20: begin r = p[31:0];  lat = 33; end
            5'd21: begin r = p[63:32]; lat = 33; end
`endif
            default: r = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one request, check latency/result, hold for 'hold' cycles, then retire it
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic        ez;
        int          el;
        int          n;
        logic        busy_ok;
        logic [31:0] held;
        model(op, a, b, er, ez, el);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check({tag, "_ready_timeout"}, 64'd0, 64'd1);
        ALU_op   = op;
        input1   = a;
        input2   = b;
        in_valid = 1'b1;
        @(negedge clk);
        busy_ok = 1'b1;
        n = 1;
        while (!out_valid && n < 200) begin
            if (in_ready) busy_ok = 1'b0;
            in_valid  = 1'($urandom);
            ALU_op    = 5'($urandom);
            input1    = $urandom;
            out_ready = 1'($urandom);
            @(negedge clk);
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'(el));
        check({tag, "_result"}, 64'(alu_out), 64'(er));
        check({tag, "_zero"}, 64'(zero), 64'(ez));
        check({tag, "_busy_in_ready"}, 64'(busy_ok), 64'd1);
        held = alu_out;
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            check({tag, "_hold_result"}, 64'(alu_out), 64'(held));
            check({tag, "_hold_valid_ready"}, {62'd0, out_valid, in_ready}, 64'b10);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_retire"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    initial begin
        rst       = 1'b1;
        ALU_op    = '0;
        input1    = '0;
        input2    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {alu_out, 29'd0, zero, out_valid, in_ready}, {32'd0, 29'd0, 3'b001});
        rst = 1'b0;
        @(negedge clk);

        run_op("add_ovf",  5'b00010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op("sra4",     5'b10000, 32'h8000_0000, 32'h0000_0004, 0);
        run_op("blt",      5'b00101, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op("bltu",     5'b00111, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op("mulhu",    5'b10101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mul",      5'b10100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("sll31",    5'b01110, 32'h0000_0003, 32'h0000_001F, 10);
        run_op("sll0",     5'b01110, 32'hDEAD_BEEF, 32'h0000_0020, 0);
        run_op("link",     5'b10011, 32'h0000_0010, 32'h0100_0000, 0);
        run_op("lui",      5'b00000, 32'h1234_5678, 32'hABCD_EFFF, 2);
        run_op("undef",    5'b11111, 32'h1234_5678, 32'h0000_0001, 0);

        // Reset in the middle of a long shift abandons it immediately
        ALU_op   = 5'b01110;
        input1   = 32'h0000_0001;
        input2   = 32'd31;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midshift_reset", {alu_out, 30'd0, out_valid, in_ready}, {32'd0, 30'd0, 2'b01});
        @(negedge clk);
        check("midshift_reset_held", {31'd0, out_valid}, 64'd0);
        rst = 1'b0;
        run_op("after_reset", 5'b01011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);

        for (int i = 0; i < 60; i++) begin
            run_op("rand", 5'($urandom_range(0, 31)), pick_val(), pick_val(),
                   ($urandom_range(0, 3) == 0) ? 2 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
